ring_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource between N requesters using a rotating one-hot priority ring.

---
 rtl/ring_pkg.sv | 40 ++++
 rtl/ring_rr_pick.sv | 34 +++
 rtl/ring_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_ring_rr_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// ring_pkg
// Shared types, defaults and helpers for the round-robin ring arbiter.
//   ring_state_e     : arbiter FSM states (IDLE, GRANT)
//   RING_N_DEFAULT   : default number of requesters
//   RING_HOLD_DEFAULT: default maximum consecutive cycles one grant is held
//   MAX_N            : widest one-hot vector the helper functions accept
//   onehot_to_index  : position of the set bit in a one-hot vector (0 when empty)
//   index_to_onehot  : one-hot vector with only bit idx set
package ring_pkg;

    localparam int RING_N_DEFAULT    = 4;
    localparam int RING_HOLD_DEFAULT = 8;
    localparam int MAX_N             = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } ring_state_e;

    // Callers zero-extend narrower vectors to MAX_N. A vector with no bit set
    // maps to index 0, which is exactly the idle encoding of gnt_id.
    function automatic int unsigned onehot_to_index(input logic [MAX_N-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_N-1:0] index_to_onehot(input int unsigned idx);
        logic [MAX_N-1:0] v;
        v = '0;
        v[idx[4:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// ring_rr_pick
// Combinational round-robin selector: starting at the one-hot position ptr
// and moving upward with wrap from N-1 to 0, picks the first set req bit.
// Ports:
//   req        in  N  level requests
//   ptr        in  N  one-hot search start position
//   pick       out N  one-hot selected requester, zero when nothing requests
//   pick_valid out 1  a requester was selected
module ring_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] pick,
    output logic         pick_valid
);

    logic [N-1:0] masked;

    // ptr-1 sets every bit below the pointer, so masked holds the requests at
    // or above the pointer. The lowest of those wins; if there are none the
    // search has wrapped and the lowest request overall wins. x & (~x + 1)
    // isolates the lowest set bit.
    always_comb begin
        masked = req & ~(ptr - N'(1));
        if (|masked) begin
            pick = masked & (~masked + N'(1));
        end else begin
            pick = req & (~req + N'(1));
        end
        pick_valid = |req;
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter
// Round-robin arbiter sharing one resource between N requesters. Grants are
// one-hot and registered, and a grant is held while its owner keeps
// requesting, for at most HOLD_MAX cycles, before priority rotates.
// Ports:
//   clk       in  1        clock, all state updates on the rising edge
//   rst_n     in  1        synchronous active-low reset
//   en        in  1        1 allows new grants; 0 lets the current grant run out
//   req       in  N        level requests, bit i = requester i
//   gnt       out N        one-hot registered grant, zero when idle
//   gnt_id    out clog2(N) index of the granted requester, 0 when idle
//   gnt_valid out 1        any grant active
//   ptr       out N        one-hot priority pointer for the next arbitration
module ring_rr_arbiter
    import ring_pkg::*;
#(
    parameter  int N        = RING_N_DEFAULT,
    parameter  int HOLD_MAX = RING_HOLD_DEFAULT,
    localparam int IW       = (N > 1) ? $clog2(N) : 1,
    localparam int CW       = $clog2(HOLD_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_valid,
    output logic [N-1:0]  ptr
);

    ring_state_e   state_q, state_d;
    logic [N-1:0]  gnt_d;
    logic [IW-1:0] gnt_id_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]  ptr_d;

    logic [N-1:0]  rot_ptr;
    logic [N-1:0]  pick_idle, pick_next;
    logic          pick_idle_valid, pick_next_valid;
    logic          owner_held;

    // The position just after the current owner is the new priority start
    // whenever a grant ends, so it is simply the grant vector rotated by one.
    assign rot_ptr    = {gnt[N-2:0], gnt[N-1]};
    assign owner_held = |(req & gnt);
    assign gnt_valid  = |gnt;

    // Arbitration from the stored pointer, used when starting from IDLE.
    ring_rr_pick #(.N(N)) u_pick_idle (
        .req        (req),
        .ptr        (ptr),
        .pick       (pick_idle),
        .pick_valid (pick_idle_valid)
    );

    // Arbitration from the slot after the owner, used for a direct hand-over.
    // When the owner is the only requester the search wraps back to it.
    ring_rr_pick #(.N(N)) u_pick_next (
        .req        (req),
        .ptr        (rot_ptr),
        .pick       (pick_next),
        .pick_valid (pick_next_valid)
    );

    // State register. Reset has priority over everything, so a grant that is
    // active when reset is sampled is dropped at that same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt        <= '0;
            gnt_id     <= '0;
            hold_cnt_q <= '0;
            ptr        <= N'(index_to_onehot(0));
        end else begin
            state_q    <= state_d;
            gnt        <= gnt_d;
            gnt_id     <= gnt_id_d;
            hold_cnt_q <= hold_cnt_d;
            ptr        <= ptr_d;
        end
    end

    // Next-state logic. The owner keeps the grant while it requests and the
    // hold budget is not spent; the count only increments below HOLD_MAX, so
    // it saturates rather than wrapping. A release or timeout always moves the
    // pointer past the owner, even when en is low, and hands the grant
    // straight to the next requester when allowed, so there is no idle gap.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt;
        gnt_id_d   = gnt_id;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr;
        unique case (state_q)
            IDLE: begin
                if (en && pick_idle_valid) begin
                    gnt_d      = pick_idle;
                    gnt_id_d   = IW'(onehot_to_index(MAX_N'(pick_idle)));
                    hold_cnt_d = CW'(1);
                    state_d    = GRANT;
                end else begin
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (owner_held && (hold_cnt_q < CW'(HOLD_MAX))) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end else begin
                    ptr_d = rot_ptr;
                    if (en && pick_next_valid) begin
                        gnt_d      = pick_next;
                        gnt_id_d   = IW'(onehot_to_index(MAX_N'(pick_next)));
                        hold_cnt_d = CW'(1);
                    end else begin
                        gnt_d      = '0;
                        gnt_id_d   = '0;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter
// Directed bench for ring_rr_arbiter with N=4, HOLD_MAX=8. Inputs change 1ns
// after a rising edge and outputs are checked at that point; structural
// properties of gnt/ptr are checked on every falling edge.
module tb_ring_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic [3:0] ptr;

    int checks;
    int failures;
    bit invOn;

    ring_rr_arbiter #(.N(4), .HOLD_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .ptr       (ptr)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected gnt_id for a given expected grant vector.
    function automatic logic [1:0] expId(input logic [3:0] g);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) id = 2'(i);
        end
        return id;
    endfunction

    // Drive inputs, then advance one rising edge and settle 1ns past it.
    task automatic applyStimulus(input logic r_n, input logic e, input logic [3:0] r);
        rst_n = r_n;
        en    = e;
        req   = r;
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs against the expected grant and pointer.
    task automatic checkOutput(input string tag, input logic [3:0] expGnt, input logic [3:0] expPtr);
        checks++;
        assert (gnt === expGnt) else begin
            failures++;
            $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, gnt, expGnt);
        end
        checks++;
        assert (gnt_valid === (|expGnt)) else begin
            failures++;
            $error("[TB] FAIL %s gnt_valid observed=%b expected=%b", tag, gnt_valid, |expGnt);
        end
        checks++;
        assert (gnt_id === expId(expGnt)) else begin
            failures++;
            $error("[TB] FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, expId(expGnt));
        end
        checks++;
        assert (ptr === expPtr) else begin
            failures++;
            $error("[TB] FAIL %s ptr observed=%b expected=%b", tag, ptr, expPtr);
        end
    endtask

    // Structural properties that must hold on every cycle after reset.
    always @(negedge clk) begin
        if (invOn) begin
            checks++;
            assert ($onehot0(gnt)) else begin
                failures++;
                $error("[TB] FAIL inv_gnt_onehot0 observed=%b expected=at most one bit", gnt);
            end
            checks++;
            assert (gnt_valid === (|gnt)) else begin
                failures++;
                $error("[TB] FAIL inv_gnt_valid observed=%b expected=%b", gnt_valid, |gnt);
            end
            checks++;
            assert (gnt_id === expId(gnt)) else begin
                failures++;
                $error("[TB] FAIL inv_gnt_id observed=%0d expected=%0d", gnt_id, expId(gnt));
            end
            checks++;
            assert ($onehot(ptr)) else begin
                failures++;
                $error("[TB] FAIL inv_ptr_onehot observed=%b expected=exactly one bit", ptr);
            end
        end
    end

    // Directed sequence: reset, full rotation, release hand-over, solo
    // timeouts, enable gating, reset during a grant.
    initial begin
        logic [3:0] expG;
        logic [3:0] expP;
        int         cnt;

        checks   = 0;
        failures = 0;
        invOn    = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = 4'b0000;

        // Reset with every requester active: nothing granted.
        applyStimulus(1'b0, 1'b1, 4'b1111);
        invOn = 1'b1;
        checkOutput("reset", 4'b0000, 4'b0001);

        // First grant one edge after reset is released.
        applyStimulus(1'b1, 1'b1, 4'b1111);
        checkOutput("first_grant", 4'b0001, 4'b0001);

        // Full rotation: each owner held 8 cycles, then the next one.
        expG = 4'b0001;
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 7; c++) begin
                applyStimulus(1'b1, 1'b1, 4'b1111);
                checkOutput("rotate_hold", expG, expG);
            end
            expG = {expG[2:0], expG[3]};
            applyStimulus(1'b1, 1'b1, 4'b1111);
            checkOutput("rotate_switch", expG, expG);
        end

        // Owner 0 drops: hand-over to 1.
        applyStimulus(1'b1, 1'b1, 4'b1110);
        checkOutput("release_to_1", 4'b0010, 4'b0010);

        // Owner 1 drops with req=1001: search starts at 2, lands on 3.
        applyStimulus(1'b1, 1'b1, 4'b1001);
        checkOutput("release_to_3", 4'b1000, 4'b0100);

        // Only requester 3 for 20 cycles: re-granted at each timeout, ptr wraps.
        cnt  = 1;
        expP = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 4'b1000);
            if (cnt == 8) begin
                cnt  = 1;
                expP = 4'b0001;
            end else begin
                cnt++;
            end
            checkOutput("solo_hold", 4'b1000, expP);
        end

        // en low: owner 3 keeps its grant until it releases.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b1000);
            checkOutput("en_low_owner_keeps", 4'b1000, 4'b0001);
        end
        applyStimulus(1'b1, 1'b0, 4'b0111);
        checkOutput("en_low_release", 4'b0000, 4'b0001);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b0111);
            checkOutput("en_low_ignored", 4'b0000, 4'b0001);
        end
        applyStimulus(1'b1, 1'b1, 4'b0111);
        checkOutput("en_high_grant", 4'b0001, 4'b0001);

        // Owner 0 drops, only 2 requests: gnt=0100 with ptr at 1.
        applyStimulus(1'b1, 1'b1, 4'b0100);
        checkOutput("grant_2", 4'b0100, 4'b0010);

        // Reset during that grant clears everything at the same edge.
        applyStimulus(1'b0, 1'b1, 4'b0100);
        checkOutput("reset_mid_grant", 4'b0000, 4'b0001);

        // No requests after reset: stays idle.
        applyStimulus(1'b1, 1'b1, 4'b0000);
        checkOutput("idle_no_req", 4'b0000, 4'b0001);

        @(negedge clk);
        invOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
